// File: rtl/countdown_timer_pkg.sv
// ============================================================================
//  Module   : countdown_timer_pkg
//  Brief    : Shared state encodings and datapath width for the countdown timer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_timer_pkg;

    localparam int c_TIMER_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOADED  = 3'd1,
        ST_RUNNING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/binary_to_7Seg.sv
// ============================================================================
//  Module   : binary_to_7Seg
//  Brief    : Hex nibble to active-high seven-segment pattern, bit order gfedcba
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_7Seg (
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (bin)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
//  Module   : countdown_timer
//  Brief    : Loadable 16-bit down-counter with pause/resume, expiry pulse,
//             optional auto-reload and four seven-segment digit outputs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                     Clkin,
    input  logic                     clear_n,
    input  logic                     load,
    input  logic [c_TIMER_WIDTH-1:0] D,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     Din,
    output logic [c_TIMER_WIDTH-1:0] Q,
    output logic                     busy,
    output logic                     expired,
    output logic                     done,
    output logic [6:0]               num0,
    output logic [6:0]               num1,
    output logic [6:0]               num2,
    output logic [6:0]               num3
);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_TIMER_WIDTH-1:0]   r_q;
    logic [c_TIMER_WIDTH-1:0]   w_q_nxt;
    logic [c_TIMER_WIDTH-1:0]   r_preset;
    logic [c_TIMER_WIDTH-1:0]   w_preset_nxt;
    logic                       r_done;
    logic                       w_done_nxt;
    logic                       w_go;
    logic [6:0]                 w_seg [4];

    always_ff @(posedge Clkin or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= ST_IDLE;
            r_q      <= '0;
            r_preset <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_preset <= w_preset_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // stop outranks start wherever both are asserted together
    assign w_go = start & ~stop;

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_preset_nxt = r_preset;
        w_done_nxt   = 1'b0;
        if (load) begin
            w_q_nxt      = D;
            w_preset_nxt = D;
            w_state_nxt  = ST_LOADED;
        end else begin
            unique case (r_state)
                ST_LOADED, ST_PAUSED: begin
                    if (w_go) begin
                        if (r_q == '0) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUNNING;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_go) begin
                        w_q_nxt = r_preset;
                        if (r_preset == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUNNING;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (stop) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (Din) begin
                        if (r_q > 16'd1) begin
                            w_q_nxt = r_q - 16'd1;
                        end else if (r_q == 16'd1) begin
                            w_done_nxt = 1'b1;
                            if (AUTO_RELOAD) begin
                                w_q_nxt = r_preset;
                            end else begin
                                w_q_nxt     = '0;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign Q       = r_q;
    assign done    = r_done;
    assign busy    = (r_state == ST_RUNNING);
    assign expired = (r_state == ST_DONE);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_seg
            binary_to_7Seg u_seg (
                .bin (r_q[gi*4 +: 4]),
                .seg (w_seg[gi])
            );
        end
    endgenerate

    assign num0 = w_seg[0];
    assign num1 = w_seg[1];
    assign num2 = w_seg[2];
    assign num3 = w_seg[3];

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
//  Module   : tb_countdown_timer
//  Brief    : Directed self-checking bench for countdown_timer (both reload modes)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    logic        Clkin;
    logic        clear_n;
    logic        load;
    logic [15:0] D;
    logic        start;
    logic        stop;
    logic        Din;

    logic [15:0] q,   ar_q;
    logic        busy, ar_busy;
    logic        expired, ar_expired;
    logic        done, ar_done;
    logic [6:0]  num0, num1, num2, num3;
    logic [6:0]  ar_num0, ar_num1, ar_num2, ar_num3;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer #(.AUTO_RELOAD(1'b0)) u_dut (
        .Clkin   (Clkin),
        .clear_n (clear_n),
        .load    (load),
        .D       (D),
        .start   (start),
        .stop    (stop),
        .Din     (Din),
        .Q       (q),
        .busy    (busy),
        .expired (expired),
        .done    (done),
        .num0    (num0),
        .num1    (num1),
        .num2    (num2),
        .num3    (num3)
    );

    countdown_timer #(.AUTO_RELOAD(1'b1)) u_dut_ar (
        .Clkin   (Clkin),
        .clear_n (clear_n),
        .load    (load),
        .D       (D),
        .start   (start),
        .stop    (stop),
        .Din     (Din),
        .Q       (ar_q),
        .busy    (ar_busy),
        .expired (ar_expired),
        .done    (ar_done),
        .num0    (ar_num0),
        .num1    (ar_num1),
        .num2    (ar_num2),
        .num3    (ar_num3)
    );

    initial Clkin = 1'b0;
    always #5 Clkin = ~Clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clkin);
        #1;
    endtask

    task automatic do_load(input logic [15:0] val);
        load = 1'b1;
        D    = val;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [15:0] ar_exp_q [6];

    initial begin
        ar_exp_q = '{16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd2};
        clear_n = 1'b0;
        load    = 1'b0;
        D       = '0;
        start   = 1'b0;
        stop    = 1'b0;
        Din     = 1'b0;
        #2;
        chk("rst_q",       q,       0);
        chk("rst_busy",    busy,    0);
        chk("rst_expired", expired, 0);
        chk("rst_done",    done,    0);
        chk("rst_num0",    num0,    7'h3F);
        tick();
        clear_n = 1'b1;
        tick();

        // Asynchronous reset while counting
        do_load(16'h0040);
        chk("ld40_q", q, 16'h0040);
        do_start();
        chk("ld40_busy", busy, 1);
        Din = 1'b1;
        tick();
        Din = 1'b0;
        chk("ld40_dec", q, 16'h003F);
        clear_n = 1'b0;
        #2;
        chk("async_q",       q,       0);
        chk("async_busy",    busy,    0);
        chk("async_expired", expired, 0);
        chk("async_num",     {num3, num2, num1, num0}, {7'h3F, 7'h3F, 7'h3F, 7'h3F});
        tick();
        clear_n = 1'b1;
        start   = 1'b1;
        Din     = 1'b1;
        tick();
        tick();
        start = 1'b0;
        Din   = 1'b0;
        chk("idle_q",    q,    0);
        chk("idle_busy", busy, 0);

        // Basic count to expiry
        do_load(16'h0003);
        do_start();
        chk("cnt_q3", q, 3);
        Din = 1'b1;
        tick();
        chk("cnt_q2", q, 2);
        chk("cnt_done2", done, 0);
        tick();
        chk("cnt_q1", q, 1);
        tick();
        Din = 1'b0;
        chk("cnt_q0",      q,       0);
        chk("cnt_done",    done,    1);
        chk("cnt_expired", expired, 1);
        chk("cnt_busy",    busy,    0);
        tick();
        chk("cnt_done_off", done,    0);
        chk("cnt_exp_hold", expired, 1);

        // Restart from DONE reloads the preset
        do_start();
        chk("restart_q",    q,    3);
        chk("restart_busy", busy, 1);

        // Pause / resume, stop wins over start
        do_load(16'h0100);
        do_start();
        Din = 1'b1;
        repeat (16) tick();
        chk("pause_pre", q, 16'h00F0);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        chk("pause_q",    q,    16'h00F0);
        chk("pause_busy", busy, 0);
        repeat (3) tick();
        chk("pause_hold", q, 16'h00F0);
        Din = 1'b0;
        do_start();
        chk("resume_busy", busy, 1);
        Din = 1'b1;
        tick();
        Din = 1'b0;
        chk("resume_q", q, 16'h00EF);

        // Zero preset expires immediately on start
        do_load(16'h0000);
        do_start();
        chk("zero_q",       q,       0);
        chk("zero_done",    done,    1);
        chk("zero_expired", expired, 1);
        tick();
        chk("zero_done_off", done, 0);
        do_load(16'h0002);
        do_start();
        chk("zero_reload_q",    q,    2);
        chk("zero_reload_busy", busy, 1);

        // load outranks Din while running
        do_load(16'h0005);
        do_start();
        load = 1'b1;
        D    = 16'h1234;
        Din  = 1'b1;
        tick();
        load = 1'b0;
        Din  = 1'b0;
        chk("prio_q",    q,    16'h1234);
        chk("prio_busy", busy, 0);
        chk("prio_exp",  expired, 0);
        chk("prio_num",  {num3, num2, num1, num0}, {7'h06, 7'h5B, 7'h4F, 7'h66});

        // Auto-reload instance
        do_load(16'h0002);
        do_start();
        chk("ar_q_start", ar_q,    2);
        chk("ar_busy",    ar_busy, 1);
        Din = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("ar_q_%0d", i),    ar_q,       ar_exp_q[i]);
            chk($sformatf("ar_done_%0d", i), ar_done,    (i % 2 == 1) ? 1 : 0);
            chk($sformatf("ar_exp_%0d", i),  ar_expired, 0);
        end
        Din = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter AUTO_RELOAD, default 0; when 1, expiry reloads the preset and counting continues.
REQ-002 Port Clkin  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port clear_n  input  1  reset, asynchronous, active-low.
REQ-004 Port load  input  1  capture D as preset and current count.
REQ-005 Port D  input  16  preset value.
REQ-006 Port start  input  1  begin or resume counting.
REQ-007 Port stop  input  1  pause counting.
REQ-008 Port Din  input  1  count-enable tick; one decrement per sampled high cycle while running.
REQ-009 Port Q  output  16  current count, registered.
REQ-010 Port busy  output  1  high while state is RUNNING.
REQ-011 Port expired  output  1  high while state is DONE.
REQ-012 Port done  output  1  registered one-cycle pulse on each expiry.
REQ-013 Ports num0, num1, num2, num3  output  7 each  seven-segment patterns of Q[3:0], Q[7:4], Q[11:8], Q[15:12]; encoding identical to binary_to_7Seg.

Function
REQ-014 States SHALL be IDLE, LOADED, RUNNING, PAUSED, DONE, held in one state register.
REQ-015 load SHALL have priority over all other inputs in every state: Q<=D, preset<=D, state<=LOADED, done<=0.
REQ-016 start in LOADED or PAUSED SHALL move to RUNNING on the same edge; start in IDLE SHALL be ignored.
REQ-017 start in DONE SHALL reload Q from preset and enter RUNNING.
REQ-018 Entering RUNNING with Q==0 SHALL instead go straight to DONE with a done pulse.
REQ-019 stop in RUNNING SHALL move to PAUSED with Q held; stop and start in the same cycle SHALL resolve as stop.
REQ-020 In RUNNING, Din high with Q>1 SHALL decrement Q by 1; Din low SHALL hold Q.
REQ-021 In RUNNING, Din high with Q==1 and AUTO_RELOAD=0 SHALL set Q<=0, state<=DONE, done<=1.
REQ-022 In RUNNING, Din high with Q==1 and AUTO_RELOAD=1 SHALL set Q<=preset and stay in RUNNING, with done<=1.
REQ-023 Q SHALL never wrap below 0; Din SHALL be ignored in all states except RUNNING.
REQ-024 done SHALL be high for exactly one cycle per expiry and low in all other cycles.
REQ-025 busy and expired SHALL decode from the state register only, with no input-to-output combinational path.
REQ-026 num0..num3 SHALL be combinational from Q and track Q in the same cycle.

Reset
REQ-027 clear_n low SHALL immediately force state=IDLE, Q=0, preset=0, done=0, busy=0, expired=0, independent of Clkin.
REQ-028 num0..num3 SHALL show the pattern for 0 while in reset.
REQ-029 Reset deasserted mid-count SHALL leave the block in IDLE; no count resumes until load.

Structure
REQ-030 State encodings and the 16-bit width constant SHALL reside in the shared timer package; the segment table SHALL NOT be duplicated there.
REQ-031 Four instances of the existing binary_to_7Seg SHALL provide the segment decode; no other sub-module.

Verification
REQ-032 Reset: clear_n low while RUNNING at Q=0x0040 -> Q=0, IDLE, busy=0, expired=0, num0..3 show 0 with no clock edge.
REQ-033 Basic count: load D=0x0003, start, 3 Din pulses -> Q 3,2,1,0; done high exactly one cycle; expired=1.
REQ-034 Pause: load 0x0100, start, 16 ticks, stop with start same cycle -> PAUSED at Q=0x00F0; further ticks hold; start resumes; Q=0x00EF after next tick.
REQ-035 Zero and restart: load 0x0000, start -> DONE next edge with done pulse; then load 0x0002, start in DONE -> Q=2, RUNNING.
REQ-036 AUTO_RELOAD=1: load 0x0002, start, 6 ticks -> Q 2,1,2,1,2,1,2 sequence, done pulse every 2nd tick, never expired.
REQ-037 Priority: load asserted with Din in RUNNING at Q=0x0005, D=0x1234 -> Q=0x1234, LOADED, no decrement, num3..num0 show 1,2,3,4.
